sram_like_bridge: RTL and testbench
===================================

SRAM_LIKE_BRIDGE -- requirements
Module: sram_like_bridge

Interface
REQ-001 Parameter DATA_W, default 32, meaning data width in bits; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, meaning address width in bits.
REQ-003 Parameter DEPTH, default 4, meaning maximum in-flight transactions; legal values are powers of 2 from 1 to 8.
REQ-004 Port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Ports io_cpu_req_valid (in, 1) and io_cpu_req_ready (out, 1): CPU request handshake.
REQ-007 Ports io_cpu_req_we (in, 1), io_cpu_req_size (in, 2), io_cpu_req_addr (in, ADDR_W), io_cpu_req_wstrb (in, DATA_W/8) and io_cpu_req_wdata (in, DATA_W): CPU request payload.
REQ-008 Ports io_cpu_resp_valid (out, 1) and io_cpu_resp_ready (in, 1): CPU response handshake.
REQ-009 Ports io_cpu_resp_we (out, 1) and io_cpu_resp_rdata (out, DATA_W): CPU response payload.
REQ-010 Ports io_mem_req (out, 1), io_mem_wr (out, 1), io_mem_size (out, 2), io_mem_addr (out, ADDR_W), io_mem_wstrb (out, DATA_W/8) and io_mem_wdata (out, DATA_W): like-SRAM request.
REQ-011 Ports io_mem_addr_ok (in, 1), io_mem_data_ok (in, 1) and io_mem_rdata (in, DATA_W): like-SRAM acceptance and return.
REQ-012 Port io_err, out, 1 bit: sticky protocol-error flag.

Function
REQ-013 credits = issued + fifo_cnt, where issued counts accepted-but-not-returned requests and fifo_cnt is response FIFO occupancy; credits SHALL never exceed DEPTH.
REQ-014 io_mem_req = io_cpu_req_valid && (credits < DEPTH); combinational, zero latency.
REQ-015 io_mem_wr, io_mem_size, io_mem_addr, io_mem_wstrb and io_mem_wdata are direct combinational copies of the CPU payload.
REQ-016 io_cpu_req_ready = io_mem_addr_ok && (credits < DEPTH).
REQ-017 A request is accepted on the cycle io_mem_req && io_mem_addr_ok; on acceptance issued increments and the we bit is pushed to an in-order tag queue of DEPTH entries.
REQ-018 On io_mem_data_ok with issued > 0: issued decrements, the tag queue pops, and {tag_we, io_mem_rdata} is pushed into the response FIFO (DEPTH entries).
REQ-019 For write responses the stored rdata is forced to 0.
REQ-020 io_cpu_resp_valid = FIFO not empty; payload is the FIFO head, registered; latency from data_ok to resp_valid is exactly 1 cycle.
REQ-021 The FIFO pops on io_cpu_resp_valid && io_cpu_resp_ready.
REQ-022 Accept, data_ok and pop in the same cycle are all honoured; each counter nets its increments and decrements.
REQ-023 io_mem_data_ok with issued == 0 SHALL set io_err, and the return is dropped; io_err clears only on reset.
REQ-024 Responses SHALL be delivered strictly in request order.
REQ-025 Counters and pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit or by the counters.

Reset
REQ-026 While reset is high: issued = 0, FIFO and tag queue empty, io_cpu_resp_valid = 0 and io_err = 0.
REQ-027 A reset asserted mid-transaction discards all in-flight state; a later data_ok then follows REQ-023.
REQ-028 Combinational outputs during reset follow REQ-014 and REQ-016 with credits = 0.

Structure
REQ-029 Package sram_like_pkg SHALL hold the size encodings (SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3) and the legal-DEPTH check constant.
REQ-030 One sub-module, sync_fifo (parametrised WIDTH and DEPTH), SHALL implement both the tag queue and the response FIFO.

Verification
REQ-031 Single read: DEPTH = 4, read addr 0x1000, addr_ok on cycle 0, data_ok with 0xDEADBEEF on cycle 3 -> resp_valid on cycle 4, rdata 0xDEADBEEF, resp_we = 0.
REQ-032 Back-pressure: hold resp_ready = 0 and issue 4 reads -> 5th request sees io_cpu_req_ready = 0 and io_mem_req = 0; releasing resp_ready drains 4 responses in order.
REQ-033 Mixed order: write, read, write with returned data 0x11 on the read -> responses we = 1/0/1, rdata 0/0x11/0.
REQ-034 Simultaneous events: at credits = 3, accept, data_ok and pop in one cycle -> credits stays 3 and no response is lost.
REQ-035 Spurious return: data_ok with issued = 0 -> io_err = 1 on the next cycle, no response produced, io_err held until reset.
REQ-036 Reset mid-flight: 2 outstanding reads, then assert reset -> FIFO empty, io_err = 0, io_cpu_req_ready = io_mem_addr_ok afterwards.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared constants for the SRAM-like bridge: transfer size encodings and the
// set of supported in-flight depths.
package sram_like_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Bit d set means DEPTH = d is supported (1, 2, 4, 8).
    localparam logic [8:0] LEGAL_DEPTH_MASK = 9'h116;

    function automatic bit depth_is_legal(input int d);
        if (d < 1 || d > 8) return 1'b0;
        return LEGAL_DEPTH_MASK[d];
    endfunction

    function automatic bit data_w_is_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the head entry is read straight from
// the storage flops so it is valid the cycle after it is written.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides what is
    // valid, and leaving the array out of reset lets it map onto plain RAM cells.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/sram_like_bridge.sv
// Bridge from a valid/ready CPU port to a like-SRAM master port, with a credit
// scheme that guarantees every accepted request has a response slot reserved.
module sram_like_bridge
    import sram_like_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_cpu_req_valid,
    output logic                io_cpu_req_ready,
    input  logic                io_cpu_req_we,
    input  logic [1:0]          io_cpu_req_size,
    input  logic [ADDR_W-1:0]   io_cpu_req_addr,
    input  logic [DATA_W/8-1:0] io_cpu_req_wstrb,
    input  logic [DATA_W-1:0]   io_cpu_req_wdata,
    output logic                io_cpu_resp_valid,
    input  logic                io_cpu_resp_ready,
    output logic                io_cpu_resp_we,
    output logic [DATA_W-1:0]   io_cpu_resp_rdata,
    output logic                io_mem_req,
    output logic                io_mem_wr,
    output logic [1:0]          io_mem_size,
    output logic [ADDR_W-1:0]   io_mem_addr,
    output logic [DATA_W/8-1:0] io_mem_wstrb,
    output logic [DATA_W-1:0]   io_mem_wdata,
    input  logic                io_mem_addr_ok,
    input  logic                io_mem_data_ok,
    input  logic [DATA_W-1:0]   io_mem_rdata,
    output logic                io_err
);

    localparam int CW = $clog2(DEPTH + 1);

    if (!depth_is_legal(DEPTH)) begin : g_bad_depth
        $fatal(1, "sram_like_bridge: DEPTH must be 1, 2, 4 or 8");
    end
    if (!data_w_is_legal(DATA_W)) begin : g_bad_data_w
        $fatal(1, "sram_like_bridge: DATA_W must be 32 or 64");
    end

    logic [CW-1:0]   issued;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     credits;
    logic            has_credit;
    logic            accept;
    logic            retire;
    logic            spurious;
    logic            resp_pop;
    logic            tag_we;
    logic [DATA_W-1:0] resp_rdata;
    logic [DATA_W:0]   resp_din;
    logic [DATA_W:0]   resp_head;

    // A slot is held from acceptance until the CPU takes the response, so the
    // response FIFO can never overflow and memory returns are never stalled.
    assign credits    = {1'b0, issued} + {1'b0, fifo_cnt};
    assign has_credit = credits < (CW + 1)'(DEPTH);

    assign io_mem_req       = io_cpu_req_valid && has_credit;
    assign io_cpu_req_ready = io_mem_addr_ok && has_credit;
    assign io_mem_wr        = io_cpu_req_we;
    assign io_mem_size      = io_cpu_req_size;
    assign io_mem_addr      = io_cpu_req_addr;
    assign io_mem_wstrb     = io_cpu_req_wstrb;
    assign io_mem_wdata     = io_cpu_req_wdata;

    assign accept   = io_mem_req && io_mem_addr_ok;
    assign retire   = io_mem_data_ok && (issued != '0);
    assign spurious = io_mem_data_ok && (issued == '0);
    assign resp_pop = io_cpu_resp_valid && io_cpu_resp_ready;

    // The tag queue occupancy is exactly the count of outstanding requests.
    sync_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .pop   (retire),
        .din   (io_cpu_req_we),
        .dout  (tag_we),
        .count (issued)
    );

    assign resp_rdata = tag_we ? '0 : io_mem_rdata;
    assign resp_din   = {tag_we, resp_rdata};

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_resp_q (
        .clock (clock),
        .reset (reset),
        .push  (retire),
        .pop   (resp_pop),
        .din   (resp_din),
        .dout  (resp_head),
        .count (fifo_cnt)
    );

    assign io_cpu_resp_valid = (fifo_cnt != '0);
    assign io_cpu_resp_we    = resp_head[DATA_W];
    assign io_cpu_resp_rdata = resp_head[DATA_W-1:0];

    // A return with nothing outstanding is dropped and latched until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_err <= 1'b0;
        end else if (spurious) begin
            io_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Randomised and directed bench for sram_like_bridge: a transaction-level model
// predicts handshakes, and a negedge monitor scores responses in order.
module tb_sram_like_bridge;
    import sram_like_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int SW     = DATA_W / 8;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [SW-1:0]     req_wstrb;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_ready;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] mem_rdata;

    logic              io_cpu_req_ready;
    logic              io_cpu_resp_valid;
    logic              io_cpu_resp_we;
    logic [DATA_W-1:0] io_cpu_resp_rdata;
    logic              io_mem_req;
    logic              io_mem_wr;
    logic [1:0]        io_mem_size;
    logic [ADDR_W-1:0] io_mem_addr;
    logic [SW-1:0]     io_mem_wstrb;
    logic [DATA_W-1:0] io_mem_wdata;
    logic              io_err;

    sram_like_bridge #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_cpu_req_valid  (req_valid),
        .io_cpu_req_ready  (io_cpu_req_ready),
        .io_cpu_req_we     (req_we),
        .io_cpu_req_size   (req_size),
        .io_cpu_req_addr   (req_addr),
        .io_cpu_req_wstrb  (req_wstrb),
        .io_cpu_req_wdata  (req_wdata),
        .io_cpu_resp_valid (io_cpu_resp_valid),
        .io_cpu_resp_ready (resp_ready),
        .io_cpu_resp_we    (io_cpu_resp_we),
        .io_cpu_resp_rdata (io_cpu_resp_rdata),
        .io_mem_req        (io_mem_req),
        .io_mem_wr         (io_mem_wr),
        .io_mem_size       (io_mem_size),
        .io_mem_addr       (io_mem_addr),
        .io_mem_wstrb      (io_mem_wstrb),
        .io_mem_wdata      (io_mem_wdata),
        .io_mem_addr_ok    (addr_ok),
        .io_mem_data_ok    (data_ok),
        .io_mem_rdata      (mem_rdata),
        .io_err            (io_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction-level model: responses owed in order, memory-side data still
    // to come back, and how many of the owed responses have already returned.
    logic [DATA_W:0]   sb[$];
    logic [DATA_W-1:0] mem_q[$];
    int                outstanding = 0;
    int                ret_cnt     = 0;
    logic              err_exp     = 1'b0;
    logic [DATA_W-1:0] acc_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic credit_ok;
        if (reset) begin
            sb.delete();
            mem_q.delete();
            outstanding = 0;
            ret_cnt     = 0;
            err_exp     = 1'b0;
        end
        credit_ok = (outstanding < DEPTH);
        check("req_ready", 64'(io_cpu_req_ready), 64'(addr_ok && credit_ok));
        check("mem_req", 64'(io_mem_req), 64'(req_valid && credit_ok));
        check("resp_valid", 64'(io_cpu_resp_valid), 64'(ret_cnt > 0));
        check("err", 64'(io_err), 64'(err_exp));
        if (req_valid) begin
            check("mem_addr", 64'(io_mem_addr), 64'(req_addr));
            check("mem_wdata", 64'(io_mem_wdata), 64'(req_wdata));
            check("mem_ctrl", 64'({io_mem_wr, io_mem_size, io_mem_wstrb}),
                  64'({req_we, req_size, req_wstrb}));
        end
        if (!reset) begin
            if (ret_cnt > 0) begin
                check("resp_payload", 64'({io_cpu_resp_we, io_cpu_resp_rdata}), 64'(sb[0]));
                if (resp_ready) begin
                    void'(sb.pop_front());
                    outstanding--;
                    ret_cnt--;
                end
            end
            if (data_ok) begin
                if (mem_q.size() > 0) begin
                    void'(mem_q.pop_front());
                    ret_cnt++;
                end else begin
                    err_exp = 1'b1;
                end
            end
            if (req_valid && credit_ok && addr_ok) begin
                sb.push_back({req_we, (req_we ? {DATA_W{1'b0}} : acc_val)});
                mem_q.push_back(acc_val);
                outstanding++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = SZ_W;
        req_addr   = '0;
        req_wstrb  = '0;
        req_wdata  = '0;
        addr_ok    = 1'b0;
        data_ok    = 1'b0;
        mem_rdata  = $urandom;
        resp_ready = 1'b1;
        acc_val    = '0;
    endtask

    task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] val);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = SZ_W;
        req_addr  = addr;
        req_wstrb = '1;
        req_wdata = $urandom;
        addr_ok   = 1'b1;
        acc_val   = val;
    endtask

    task automatic ret();
        data_ok   = 1'b1;
        mem_rdata = (mem_q.size() > 0) ? mem_q[0] : 32'hBAD0_BAD0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && (mem_q.size() > 0 || sb.size() > 0); i++) begin
            idle();
            if (mem_q.size() > 0) ret();
            tick();
        end
        idle();
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) tick();
        @(negedge clock);
        check("reset_resp_valid", 64'(io_cpu_resp_valid), 64'd0);
        check("reset_err", 64'(io_err), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single read with return three cycles after acceptance.
        idle(); send(1'b0, 32'h1000, 32'hDEAD_BEEF); tick();
        idle(); tick();
        tick();
        ret(); @(negedge clock);
        check("single_valid_early", 64'(io_cpu_resp_valid), 64'd0);
        tick();
        idle(); @(negedge clock);
        check("single_valid", 64'(io_cpu_resp_valid), 64'd1);
        check("single_rdata", 64'(io_cpu_resp_rdata), 64'hDEAD_BEEF);
        check("single_we", 64'(io_cpu_resp_we), 64'd0);
        tick();

        // Back-pressure: four reads fill every credit.
        for (int i = 0; i < 4; i++) begin
            idle(); resp_ready = 1'b0; send(1'b0, 32'h2000 + 32'(i * 4), 32'hA0 + 32'(i)); tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle(); resp_ready = 1'b0; ret(); tick();
        end
        idle(); resp_ready = 1'b0; send(1'b0, 32'h3000, 32'hFF);
        @(negedge clock);
        check("bp_req_ready", 64'(io_cpu_req_ready), 64'd0);
        check("bp_mem_req", 64'(io_mem_req), 64'd0);
        tick();
        drain("bp_drain");

        // Mixed write/read/write ordering.
        idle(); send(1'b1, 32'h4000, 32'h1234_5678); tick();
        idle(); send(1'b0, 32'h4004, 32'h11); tick();
        idle(); send(1'b1, 32'h4008, 32'h9ABC_DEF0); tick();
        drain("mixed_drain");

        // Accept, return and pop all in one cycle at three credits.
        for (int i = 0; i < 3; i++) begin
            idle(); resp_ready = 1'b0; send(1'b0, 32'h5000 + 32'(i * 4), 32'hC0 + 32'(i)); tick();
        end
        idle(); resp_ready = 1'b0; ret(); tick();
        idle(); send(1'b0, 32'h5010, 32'hC3); ret(); resp_ready = 1'b1;
        @(negedge clock);
        check("simul_ready", 64'(io_cpu_req_ready), 64'd1);
        tick();
        idle(); resp_ready = 1'b0; send(1'b0, 32'h5014, 32'hC4);
        @(negedge clock);
        check("simul_credit3", 64'(io_cpu_req_ready), 64'd1);
        tick();
        idle(); resp_ready = 1'b0; addr_ok = 1'b1;
        @(negedge clock);
        check("simul_full", 64'(io_cpu_req_ready), 64'd0);
        tick();
        drain("simul_drain");

        // Spurious return with nothing outstanding.
        idle(); data_ok = 1'b1; mem_rdata = 32'h1234; tick();
        idle(); @(negedge clock);
        check("spur_err", 64'(io_err), 64'd1);
        check("spur_no_resp", 64'(io_cpu_resp_valid), 64'd0);
        repeat (4) tick();
        @(negedge clock);
        check("spur_err_held", 64'(io_err), 64'd1);
        tick();

        // Reset with two reads in flight.
        idle(); send(1'b0, 32'h6000, 32'h1); tick();
        idle(); send(1'b0, 32'h6004, 32'h2); tick();
        idle(); reset = 1'b1; tick();
        @(negedge clock);
        check("rst_resp_valid", 64'(io_cpu_resp_valid), 64'd0);
        check("rst_err", 64'(io_err), 64'd0);
        addr_ok = 1'b1; #1;
        check("rst_ready_hi", 64'(io_cpu_req_ready), 64'd1);
        addr_ok = 1'b0; #1;
        check("rst_ready_lo", 64'(io_cpu_req_ready), 64'd0);
        tick();
        reset = 1'b0; idle(); tick();
        idle(); addr_ok = 1'b1; send(1'b0, 32'h6008, 32'h3); req_valid = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 64'(io_cpu_req_ready), 64'd1);
        tick();
        idle(); data_ok = 1'b1; tick();
        idle(); @(negedge clock);
        check("post_rst_spur_err", 64'(io_err), 64'd1);
        tick();
        reset = 1'b1; repeat (2) tick();
        reset = 1'b0; tick();

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 9) < 6);
            req_we     = 1'($urandom_range(0, 1));
            req_size   = 2'($urandom_range(0, 3));
            req_addr   = $urandom;
            req_wstrb  = SW'($urandom);
            req_wdata  = $urandom;
            acc_val    = $urandom;
            addr_ok    = ($urandom_range(0, 9) < 6);
            resp_ready = ($urandom_range(0, 9) < 7);
            if (mem_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                data_ok   = 1'b1;
                mem_rdata = mem_q[0];
            end else begin
                data_ok   = 1'b0;
                mem_rdata = $urandom;
            end
            tick();
        end
        drain("random_drain");
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
